// File: rtl/asap_er_scanner.sv
// Read-side ER scanner: walks ER_min..ER_max over a read port and builds a
// Fletcher-style {sumB,sumA} digest, valid only if exec held for the whole scan.
module asap_er_scanner #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_er_min,
  input  logic [15:0] i_er_max,
  input  logic        i_exec,
  output logic        o_rd_req,
  output logic [15:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic [15:0] i_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_digest
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_er_max;
  logic [15:0]   r_addr;
  logic [15:0]   r_sum_a;
  logic [15:0]   r_sum_b;
  logic          r_exec_ok;
  logic [TW-1:0] r_tcnt;
  logic          r_rd_req;
  logic          r_busy;
  logic          r_valid;
  logic          r_err;
  logic [31:0]   r_digest;

  logic          w_bounds_bad;
  logic          w_last;
  logic          w_tmo;
  logic [16:0]   w_s;
  logic [16:0]   w_t;
  logic [15:0]   w_sum_a_nxt;
  logic [15:0]   w_sum_b_nxt;

  assign w_bounds_bad = (i_er_min > i_er_max) | i_er_min[0] | i_er_max[0];
  assign w_last       = (r_addr == r_er_max);
  assign w_tmo        = (r_tcnt == TCNT_LAST);

  // ones'-complement adds: fold the carry back into bit 0
  assign w_s         = {1'b0, r_sum_a} + {1'b0, i_rd_data};
  assign w_sum_a_nxt = w_s[15:0] + {15'd0, w_s[16]};
  assign w_t         = {1'b0, r_sum_b} + {1'b0, w_sum_a_nxt};
  assign w_sum_b_nxt = w_t[15:0] + {15'd0, w_t[16]};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = w_bounds_bad ? S_FIN : S_SCAN;
      S_SCAN: begin
        if (i_rd_ack) begin
          if (w_last) w_state_nxt = S_FIN;
        end else if (w_tmo) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_done = (r_state == S_FIN);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_er_max  <= '0;
      r_addr    <= '0;
      r_sum_a   <= '0;
      r_sum_b   <= '0;
      r_exec_ok <= 1'b0;
      r_tcnt    <= '0;
      r_rd_req  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_digest  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_er_max <= i_er_max;
            r_valid  <= 1'b0;
            r_digest <= '0;
            if (w_bounds_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err     <= 1'b0;
              r_addr    <= i_er_min;
              r_sum_a   <= '0;
              r_sum_b   <= '0;
              r_exec_ok <= i_exec;
              r_tcnt    <= '0;
              r_rd_req  <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (!i_exec) r_exec_ok <= 1'b0;
          if (i_rd_ack) begin
            r_sum_a <= w_sum_a_nxt;
            r_sum_b <= w_sum_b_nxt;
            if (w_last) begin
              r_rd_req <= 1'b0;
            end else begin
              r_addr <= r_addr + 16'd2;
              r_tcnt <= '0;
            end
          end else if (w_tmo) begin
            r_rd_req <= 1'b0;
            r_err    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_FIN: begin
          r_busy   <= 1'b0;
          r_digest <= r_err ? 32'd0 : {r_sum_b, r_sum_a};
          r_valid  <= r_exec_ok & ~r_err;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_req  = r_rd_req;
  assign o_rd_addr = r_addr;
  assign o_busy    = r_busy;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_digest  = r_digest;

endmodule

// File: tb/tb_asap_er_scanner.sv
// Directed bench for asap_er_scanner: scans a small ER image and checks
// digest, flags, latency, timeout and reset-abort behaviour.
module tb_asap_er_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] er_min;
  logic [15:0] er_max;
  logic        exec;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        valid;
  logic        err;
  logic [31:0] digest;

  logic [15:0] mem [0:7];
  logic [15:0] w_off;

  int n_checks = 0;
  int n_fail   = 0;

  asap_er_scanner dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_er_min  (er_min),
    .i_er_max  (er_max),
    .i_exec    (exec),
    .o_rd_req  (rd_req),
    .o_rd_addr (rd_addr),
    .i_rd_ack  (rd_ack),
    .i_rd_data (rd_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_valid   (valid),
    .o_err     (err),
    .o_digest  (digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_off   = (rd_addr - 16'hE000) >> 1;
  assign rd_data = mem[w_off[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at edge 0; cycle c is the interval after edge c-1.
  task automatic do_scan(input logic [15:0] mn, input logic [15:0] mx, input int glitch,
                         input int budget, output int done_cyc, output int req_cyc,
                         output logic busy1);
    done_cyc = -1;
    req_cyc  = 0;
    busy1    = 1'b0;
    start  = 1'b1;
    er_min = mn;
    er_max = mx;
    tick();
    start = 1'b0;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      exec = (c == glitch) ? 1'b0 : 1'b1;
      if (c == 1) busy1 = busy;
      if (rd_req) req_cyc++;
      if (done) done_cyc = c;
      else      tick();
    end
    exec = 1'b1;
    if (done_cyc < 0) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  int   dc, rc;
  logic b1;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    er_min = '0;
    er_max = '0;
    exec   = 1'b1;
    rd_ack = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    tick();
    tick();
    reset = 1'b0;

    check("rst_rd_req",  {31'd0, rd_req}, 32'd0);
    check("rst_busy",    {31'd0, busy},   32'd0);
    check("rst_done",    {31'd0, done},   32'd0);
    check("rst_valid",   {31'd0, valid},  32'd0);
    check("rst_err",     {31'd0, err},    32'd0);
    check("rst_digest",  digest,          32'd0);
    check("rst_rd_addr", {16'd0, rd_addr}, 32'd0);

    // 1: two words, ack always
    mem[0] = 16'h0001; mem[1] = 16'h0002;
    do_scan(16'hE000, 16'hE002, 0, 20, dc, rc, b1);
    check("t1_done_cyc", dc, 3);
    check("t1_req_cyc",  rc, 2);
    check("t1_busy1",    {31'd0, b1}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_digest", digest, 32'h0004_0003);
    check("t1_valid",  {31'd0, valid}, 32'd1);
    check("t1_err",    {31'd0, err},   32'd0);
    check("t1_busy",   {31'd0, busy},  32'd0);

    // 2: exec dropped for one cycle mid-scan
    do_scan(16'hE000, 16'hE002, 2, 20, dc, rc, b1);
    tick();
    check("t2_digest", digest, 32'h0004_0003);
    check("t2_valid",  {31'd0, valid}, 32'd0);
    check("t2_err",    {31'd0, err},   32'd0);

    // 3: end-around carry
    mem[0] = 16'hFFFF; mem[1] = 16'h0002;
    do_scan(16'hE000, 16'hE002, 0, 20, dc, rc, b1);
    tick();
    check("t3_digest", digest, 32'h0002_0002);
    check("t3_valid",  {31'd0, valid}, 32'd1);

    // four words: sumA 1,3,6,10  sumB 1,4,10,20
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    do_scan(16'hE000, 16'hE006, 0, 20, dc, rc, b1);
    check("t3b_done_cyc", dc, 5);
    tick();
    check("t3b_digest", digest, 32'h0014_000A);

    // 4: inverted bounds
    do_scan(16'hE004, 16'hE000, 0, 20, dc, rc, b1);
    check("t4_req_cyc", rc, 0);
    tick();
    check("t4_err",    {31'd0, err},   32'd1);
    check("t4_valid",  {31'd0, valid}, 32'd0);
    check("t4_digest", digest, 32'd0);

    // odd ER_min
    do_scan(16'hE001, 16'hE003, 0, 20, dc, rc, b1);
    check("t4b_req_cyc", rc, 0);
    tick();
    check("t4b_err", {31'd0, err}, 32'd1);

    // 5: ack never comes
    rd_ack = 1'b0;
    do_scan(16'hE000, 16'hE002, 0, 300, dc, rc, b1);
    check("t5_req_cyc",  rc, 255);
    check("t5_done_cyc", dc, 256);
    tick();
    check("t5_err",    {31'd0, err},   32'd1);
    check("t5_valid",  {31'd0, valid}, 32'd0);
    check("t5_digest", digest, 32'd0);

    // 6: reset mid-scan, then a normal scan
    start = 1'b1; er_min = 16'hE000; er_max = 16'hE002;
    tick();
    start = 1'b0;
    tick();
    check("t6_req_before", {31'd0, rd_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_req_after",  {31'd0, rd_req}, 32'd0);
    check("t6_busy_after", {31'd0, busy},   32'd0);
    check("t6_done_after", {31'd0, done},   32'd0);
    tick();
    check("t6_no_done", {31'd0, done}, 32'd0);
    rd_ack = 1'b1;
    mem[0] = 16'h0001; mem[1] = 16'h0002;
    do_scan(16'hE000, 16'hE002, 0, 20, dc, rc, b1);
    check("t6_done_cyc", dc, 3);
    tick();
    check("t6_digest", digest, 32'h0004_0003);
    check("t6_valid",  {31'd0, valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
